// File: rtl/g_gate_pkg.sv
// Shared constants, lane function and parameter legality check for the g_* gate-bank family.
`ifndef G_GATE_PKG_SV
`define G_GATE_PKG_SV

`define G_CHECK_PARAMS(nin, width, lat, mask) \
   if ((nin) < 2 || (nin) > g_gate_pkg::G_MAX_NIN || (width) < 1 || (width) > g_gate_pkg::G_MAX_WIDTH || \
       (lat) < 1 || (lat) > g_gate_pkg::G_MAX_LATENCY || $bits(mask) != (nin)) begin : g_param_error \
      $error("g_gate: illegal NIN/WIDTH/LATENCY/INV_MASK combination"); \
   end

package g_gate_pkg;

   localparam int G_MAX_NIN     = 8;
   localparam int G_MAX_LATENCY = 4;
   localparam int G_MAX_WIDTH   = 64;

   typedef logic [G_MAX_NIN-1:0][G_MAX_WIDTH-1:0] g_operands_t;

   // Unused operand slots must be zero with a clear mask bit so they cannot disturb the OR.
   function automatic logic [G_MAX_WIDTH-1:0] g_lane_eval(
      input g_operands_t            operands,
      input logic [G_MAX_NIN-1:0]   inv_mask,
      input logic                   out_inv
   );
      logic [G_MAX_WIDTH-1:0] t;
      t = '0;
      for (int i = 0; i < G_MAX_NIN; i++) begin
         t = t | (operands[i] ^ {G_MAX_WIDTH{inv_mask[i]}});
      end
      return out_inv ? ~t : t;
   endfunction

endpackage

`endif

// File: rtl/g_pipe_stage.sv
// One pipeline slot: WIDTH data bits plus valid, with the backward ready term for the slot upstream.
module g_pipe_stage #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             v_in,
   input  logic             rdy_in,
   output logic [WIDTH-1:0] data_q,
   output logic             v_q,
   output logic             rdy_out
);

   logic [WIDTH-1:0] data_d;
   logic             v_d;

   // Data only loads alongside a valid so that garbage on an idle input never reaches the register.
   always_comb begin
      rdy_out = ~v_q | rdy_in;
      v_d     = v_q;
      data_d  = data_q;
      if (rdy_out) begin
         v_d = v_in;
         if (v_in) begin
            data_d = data_in;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         v_q    <= 1'b0;
      end else begin
         data_q <= data_d;
         v_q    <= v_d;
      end
   end

endmodule

// File: rtl/g_nnor_pipe.sv
// Registered, back-pressurable bank of NIN-input NOR/OR gates with per-input inversion.
module g_nnor_pipe
   import g_gate_pkg::*;
#(
   parameter int NIN      = 3,
   parameter int WIDTH    = 1,
   parameter     INV_MASK = 3'b011,
   parameter bit OUT_INV  = 1'b1,
   parameter int LATENCY  = 1
) (
   input  logic                 CLK,
   input  logic                 RN,
   input  logic [NIN*WIDTH-1:0] D,
   input  logic                 VI,
   output logic                 RI,
   output logic [WIDTH-1:0]     YN,
   output logic                 VO,
   input  logic                 RO
);

   `G_CHECK_PARAMS(NIN, WIDTH, LATENCY, INV_MASK)

   localparam logic [NIN-1:0] INV_BITS = INV_MASK[NIN-1:0];

   g_operands_t          ops_pad;
   logic [G_MAX_NIN-1:0] mask_pad;
   logic [WIDTH-1:0]     lane_f;

   always_comb begin
      ops_pad  = '0;
      mask_pad = '0;
      for (int i = 0; i < NIN; i++) begin
         ops_pad[i][WIDTH-1:0] = D[i*WIDTH +: WIDTH];
         mask_pad[i]           = INV_BITS[i];
      end
      lane_f = WIDTH'(g_lane_eval(ops_pad, mask_pad, OUT_INV));
   end

   logic [WIDTH-1:0] data_c [0:LATENCY];
   logic             v_c    [0:LATENCY];
   logic             rdy_c  [1:LATENCY+1];

   assign data_c[0]         = lane_f;
   assign v_c[0]            = VI;
   assign rdy_c[LATENCY+1]  = RO;

   // Ready ripples back combinationally from RO, so a full pipe accepts in the cycle it drains.
   for (genvar k = 1; k <= LATENCY; k++) begin : g_stage
      g_pipe_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk     (CLK),
         .rst_n   (RN),
         .data_in (data_c[k-1]),
         .v_in    (v_c[k-1]),
         .rdy_in  (rdy_c[k+1]),
         .data_q  (data_c[k]),
         .v_q     (v_c[k]),
         .rdy_out (rdy_c[k])
      );
   end

   assign RI = rdy_c[1];
   assign YN = data_c[LATENCY];
   assign VO = v_c[LATENCY];

endmodule

// File: tb/tb_g_nnor_pipe.sv
// Randomised and directed bench for g_nnor_pipe, checked against a queue-based reference model.
module tb_g_nnor_pipe;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic rstN;

   logic [2:0]  aD;
   logic        aVi, aRi, aVo, aRo;
   logic [0:0]  aYn;
   logic [31:0] bD;
   logic        bVi, bRi, bVo, bRo;
   logic [7:0]  bYn;
   logic [7:0]  cD;
   logic        cVi, cRi, cVo, cRo;
   logic [3:0]  cYn;

   g_nnor_pipe dutA (
      .CLK (clock), .RN (rstN), .D (aD), .VI (aVi), .RI (aRi), .YN (aYn), .VO (aVo), .RO (aRo)
   );

   g_nnor_pipe #(
      .NIN (4), .WIDTH (8), .INV_MASK (4'b0000), .OUT_INV (1'b0), .LATENCY (3)
   ) dutB (
      .CLK (clock), .RN (rstN), .D (bD), .VI (bVi), .RI (bRi), .YN (bYn), .VO (bVo), .RO (bRo)
   );

   g_nnor_pipe #(
      .NIN (2), .WIDTH (4), .INV_MASK (2'b10), .OUT_INV (1'b1), .LATENCY (2)
   ) dutC (
      .CLK (clock), .RN (rstN), .D (cD), .VI (cVi), .RI (cRi), .YN (cYn), .VO (cVo), .RO (cRo)
   );

   int          vectorCount = 0;
   int          missCount   = 0;
   int          cycleNo     = 0;
   bit          strictLat;
   logic [63:0] qA[$], qB[$], qC[$];
   int          tA[$], tB[$], tC[$];
   int          emitCount [3] = '{0, 0, 0};
   logic [63:0] lastY [3];
   int          ninTab   [3] = '{3, 4, 2};
   int          widthTab [3] = '{1, 8, 4};
   logic [7:0]  maskTab  [3] = '{8'b011, 8'b0000, 8'b10};
   bit          invTab   [3] = '{1'b1, 1'b0, 1'b1};
   int          latTab   [3] = '{1, 3, 2};

   logic [7:0]  stallVecs [6];
   int          idx, guard, acceptsAtStall, emittedBefore;

   // Expected result straight from the gate definition: invert chosen operands, OR them, optionally invert.
   function automatic logic [63:0] refEval(input logic [63:0] d, input int nin, input int width,
                                           input logic [7:0] mask, input bit outInv);
      logic [63:0] lanes, acc, op;
      lanes = (64'd1 << width) - 64'd1;
      acc   = '0;
      for (int i = 0; i < nin; i++) begin
         op = (d >> (i * width)) & lanes;
         if (mask[i]) op = ~op & lanes;
         acc = acc | op;
      end
      return outInv ? (~acc & lanes) : acc;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Items accepted but not yet emitted equal occupied stages, which fixes RI and the idle VO.
   task automatic scoreboard(input int sel, input logic vi, input logic ri, input logic vo,
                             input logic ro, input logic [63:0] yn, input logic [63:0] d);
      int          depth;
      int          tAcc;
      logic [63:0] expY;
      depth = (sel == 0) ? qA.size() : (sel == 1) ? qB.size() : qC.size();
      checkOutput($sformatf("ready%0d", sel), ri, !(depth == latTab[sel] && !ro));
      if (depth == 0) begin
         checkOutput($sformatf("idleValid%0d", sel), vo, 1'b0);
      end else if (vo && ro) begin
         case (sel)
            0:       begin expY = qA.pop_front(); tAcc = tA.pop_front(); end
            1:       begin expY = qB.pop_front(); tAcc = tB.pop_front(); end
            default: begin expY = qC.pop_front(); tAcc = tC.pop_front(); end
         endcase
         checkOutput($sformatf("result%0d", sel), yn, expY);
         emitCount[sel]++;
         lastY[sel] = expY;
         if (strictLat) checkOutput($sformatf("latency%0d", sel), cycleNo - tAcc, latTab[sel]);
         else checkOutput($sformatf("latencyMin%0d", sel), (cycleNo - tAcc) >= latTab[sel], 1'b1);
      end
      if (vi && ri) begin
         expY = refEval(d, ninTab[sel], widthTab[sel], maskTab[sel], invTab[sel]);
         case (sel)
            0:       begin qA.push_back(expY); tA.push_back(cycleNo); end
            1:       begin qB.push_back(expY); tB.push_back(cycleNo); end
            default: begin qC.push_back(expY); tC.push_back(cycleNo); end
         endcase
      end
   endtask

   task automatic applyStimulus(input int sel, input logic vi, input logic [31:0] d, input logic ro);
      @(negedge clock);
      case (sel)
         0:       begin aVi = vi; aD = d[2:0]; aRo = ro; end
         1:       begin bVi = vi; bD = d;      bRo = ro; end
         default: begin cVi = vi; cD = d[7:0]; cRo = ro; end
      endcase
      #1;
      scoreboard(0, aVi, aRi, aVo, aRo, 64'(aYn), 64'(aD));
      scoreboard(1, bVi, bRi, bVo, bRo, 64'(bYn), 64'(bD));
      scoreboard(2, cVi, cRi, cVo, cRo, 64'(cYn), 64'(cD));
      cycleNo++;
   endtask

   task automatic clearModel();
      qA.delete(); qB.delete(); qC.delete();
      tA.delete(); tB.delete(); tC.delete();
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rstN = 1'b1;
      aVi = 0; aD = '0; aRo = 0;
      bVi = 0; bD = '0; bRo = 0;
      cVi = 0; cD = '0; cRo = 0;
      strictLat = 1'b1;

      // Reset acts immediately, before any clock edge.
      #2 rstN = 1'b0;
      #1;
      checkOutput("resetValidA", aVo, 1'b0);
      checkOutput("resetDataA",  64'(aYn), 64'd0);
      checkOutput("resetValidB", bVo, 1'b0);
      checkOutput("resetDataB",  64'(bYn), 64'd0);
      checkOutput("resetValidC", cVo, 1'b0);
      checkOutput("resetDataC",  64'(cYn), 64'd0);
      repeat (2) @(negedge clock);
      aRo = 1; bRo = 1; cRo = 1;
      rstN = 1'b1;
      #1;
      checkOutput("releaseReadyA", aRi, 1'b1);
      checkOutput("releaseReadyB", bRi, 1'b1);
      checkOutput("releaseReadyC", cRi, 1'b1);

      // Full truth table of the default AN/BN/C gate, each result exactly one cycle later.
      for (int v = 0; v < 8; v++) applyStimulus(0, 1'b1, 32'(v), 1'b1);
      repeat (3) applyStimulus(0, 1'b0, 32'd0, 1'b1);
      checkOutput("sweepCount", emitCount[0], 8);

      // Bus-mode OR of four bytes, result valid on the third cycle.
      applyStimulus(1, 1'b1, 32'h8000_0201, 1'b1);
      repeat (3) applyStimulus(1, 1'b0, 32'd0, 1'b1);
      checkOutput("busValid",  bVo, 1'b1);
      checkOutput("busResult", 64'(bYn), 64'h83);
      repeat (2) applyStimulus(1, 1'b0, 32'd0, 1'b1);

      // Back-pressure: six vectors into the two-stage pipe with RO low for four cycles.
      strictLat = 1'b0;
      for (int n = 0; n < 6; n++) stallVecs[n] = 8'($urandom);
      idx = 0; guard = 0; acceptsAtStall = -1; emittedBefore = emitCount[2];
      while (idx < 6 && guard < 40) begin
         applyStimulus(2, 1'b1, 32'(stallVecs[idx]), guard >= 4);
         if (!cRi && acceptsAtStall < 0) acceptsAtStall = idx;
         if (cRi) idx++;
         guard++;
      end
      repeat (6) applyStimulus(2, 1'b0, 32'd0, 1'b1);
      checkOutput("stallAccepts",  acceptsAtStall, 2);
      checkOutput("streamEmitted", emitCount[2] - emittedBefore, 6);
      checkOutput("streamDrained", qC.size(), 0);

      // Full single-stage pipe: raising RO accepts and emits in the same cycle.
      applyStimulus(0, 1'b1, 32'b011, 1'b0);
      applyStimulus(0, 1'b1, 32'b100, 1'b0);
      checkOutput("fullReady", aRi, 1'b0);
      applyStimulus(0, 1'b1, 32'b100, 1'b1);
      checkOutput("simulReady", aRi, 1'b1);
      checkOutput("simulEmit",  aVo && aRo, 1'b1);
      repeat (2) applyStimulus(0, 1'b0, 32'd0, 1'b1);

      // Random traffic with random back-pressure on every configuration.
      for (int sel = 0; sel < 3; sel++) begin
         for (int n = 0; n < 150; n++)
            applyStimulus(sel, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 9) < 7);
         repeat (6) applyStimulus(sel, 1'b0, 32'd0, 1'b1);
      end
      checkOutput("drainA", qA.size(), 0);
      checkOutput("drainB", qB.size(), 0);
      checkOutput("drainC", qC.size(), 0);

      // Reset with three results in flight: outputs clear at once and nothing stale follows.
      for (int n = 0; n < 3; n++) applyStimulus(1, 1'b1, $urandom, 1'b0);
      @(negedge clock);
      checkOutput("preResetValid", bVo, 1'b1);
      #2 rstN = 1'b0;
      #1;
      checkOutput("midResetValid", bVo, 1'b0);
      checkOutput("midResetData",  64'(bYn), 64'd0);
      clearModel();
      bVi = 1'b0; bRo = 1'b1;
      @(negedge clock);
      rstN = 1'b1;
      repeat (5) applyStimulus(1, 1'b0, 32'd0, 1'b1);
      checkOutput("postResetQuiet", bVo, 1'b0);

      // Idle hold: X on D with VI low leaves the last result untouched.
      strictLat = 1'b1;
      applyStimulus(0, 1'b1, 32'b011, 1'b1);
      applyStimulus(0, 1'b0, 32'd0, 1'b1);
      for (int n = 0; n < 4; n++) begin
         applyStimulus(0, 1'b0, (n % 2 == 0) ? 32'hxxxx_xxxx : 32'hffff_ffff, 1'b1);
         checkOutput("holdData",  64'(aYn), lastY[0]);
         checkOutput("holdValid", aVo, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
